// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flip-flop walk
// the operands LSB first, one bit per clock, behind a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_sum;
    logic               r_c;
    logic               r_cout;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_last;
    logic               w_sbit;
    logic               w_cnxt;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_sbit   = r_sa[0] ^ r_sb[0] ^ r_c;
    assign w_cnxt   = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_c) | (r_sb[0] & r_c);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert B on capture and preload the carry with 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_sum  <= '0;
            r_c    <= 1'b0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_sa  <= a;
            r_sb  <= sub ? ~b : b;
            r_c   <= sub ? 1'b1 : cin;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_sum <= {w_sbit, r_sum[WIDTH-1:1]};
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_c   <= w_cnxt;
            r_cnt <= r_cnt + CNT_W'(1);
            // On the MSB, r_c is the carry into the sign bit and w_cnxt the carry out.
            if (w_last) begin
                r_cout <= w_cnxt;
                r_ovf  <= r_c ^ w_cnxt;
            end
        end
    end

    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH 8, 16 and 4 instances share one
// stimulus path selected by 'sel'; results are checked against arithmetic.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int          sel = 8;
    logic        start_drv = 1'b0;
    logic        sub_drv = 1'b0;
    logic        cin_drv = 1'b0;
    logic [31:0] a_drv = '0;
    logic [31:0] b_drv = '0;

    logic [7:0]  sum8;
    logic        cout8, ovf8, busy8, done8;
    logic [15:0] sum16;
    logic        cout16, ovf16, busy16, done16;
    logic [3:0]  sum4;
    logic        cout4, ovf4, busy4, done4;

    logic [31:0] sum_o;
    logic        cout_o, ovf_o, busy_o, done_o;

    int          nchk = 0;
    int          nfail = 0;
    logic [31:0] prev_sum [0:2];
    logic        prev_cout [0:2];
    logic        prev_ovf [0:2];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .reset_n(reset_n), .start(start_drv && (sel == 8)), .sub(sub_drv),
        .a(a_drv[7:0]), .b(b_drv[7:0]), .cin(cin_drv),
        .sum(sum8), .cout(cout8), .overflow(ovf8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(16)) u16 (
        .clk(clk), .reset_n(reset_n), .start(start_drv && (sel == 16)), .sub(sub_drv),
        .a(a_drv[15:0]), .b(b_drv[15:0]), .cin(cin_drv),
        .sum(sum16), .cout(cout16), .overflow(ovf16), .busy(busy16), .done(done16)
    );

    serial_adder #(.WIDTH(4)) u4 (
        .clk(clk), .reset_n(reset_n), .start(start_drv && (sel == 4)), .sub(sub_drv),
        .a(a_drv[3:0]), .b(b_drv[3:0]), .cin(cin_drv),
        .sum(sum4), .cout(cout4), .overflow(ovf4), .busy(busy4), .done(done4)
    );

    always_comb begin
        sum_o  = '0;
        cout_o = 1'b0;
        ovf_o  = 1'b0;
        busy_o = 1'b0;
        done_o = 1'b0;
        case (sel)
            4:  begin sum_o = {28'b0, sum4};  cout_o = cout4;  ovf_o = ovf4;  busy_o = busy4;  done_o = done4;  end
            16: begin sum_o = {16'b0, sum16}; cout_o = cout16; ovf_o = ovf16; busy_o = busy16; done_o = done16; end
            default: begin sum_o = {24'b0, sum8}; cout_o = cout8; ovf_o = ovf8; busy_o = busy8; done_o = done8; end
        endcase
    end

    function automatic int idx_of(input int w);
        return (w == 4) ? 0 : ((w == 8) ? 1 : 2);
    endfunction

    // Reference: plain integer arithmetic, result = {overflow, cout, sum}.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        longint unsigned mask, av, bv, full, s;
        logic co, sa, sb, ss, ov;
        mask = (64'd1 << w) - 64'd1;
        av   = a & mask;
        bv   = sub ? (~b & mask) : (b & mask);
        full = av + bv + (sub ? 64'd1 : longint'(cin));
        s    = full & mask;
        co   = full[w];
        sa   = av[w-1];
        sb   = bv[w-1];
        ss   = s[w-1];
        ov   = (sa == sb) && (ss != sa);
        return {ov, co, s[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_prev();
        for (int i = 0; i < 3; i++) begin
            prev_sum[i]  = '0;
            prev_cout[i] = 1'b0;
            prev_ovf[i]  = 1'b0;
        end
    endtask

    // One full operation on the selected instance, with handshake and hold checks.
    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        int          w;
        int          ix;
        int          done_at;
        int          busy_n;
        int          done_n;
        logic [33:0] exp;
        w   = sel;
        ix  = idx_of(w);
        exp = model(w, a, b, cin, sub);
        @(negedge clk);
        a_drv = a; b_drv = b; cin_drv = cin; sub_drv = sub; start_drv = 1'b1;
        @(posedge clk);
        #1;
        start_drv = 1'b0;
        a_drv = $urandom; b_drv = $urandom; cin_drv = 1'($urandom); sub_drv = 1'($urandom);
        busy_n = 0; done_n = 0; done_at = -1;
        for (int k = 1; k <= w + 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("hold_sum", sum_o, prev_sum[ix]);
                chk("hold_cout", 32'(cout_o), 32'(prev_cout[ix]));
                chk("hold_ovf", 32'(ovf_o), 32'(prev_ovf[ix]));
            end
            if (k == 3) begin
                a_drv = $urandom; b_drv = $urandom; cin_drv = 1'($urandom); sub_drv = 1'($urandom);
            end
            if (busy_o) busy_n++;
            if (done_o) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
        end
        chk("done_cycle", 32'(done_at), 32'(w + 1));
        chk("busy_cycles", 32'(busy_n), 32'(w));
        chk("done_pulses", 32'(done_n), 32'd1);
        chk("sum", sum_o, exp[31:0]);
        chk("cout", 32'(cout_o), 32'(exp[32]));
        chk("overflow", 32'(ovf_o), 32'(exp[33]));
        prev_sum[ix]  = exp[31:0];
        prev_cout[ix] = exp[32];
        prev_ovf[ix]  = exp[33];
    endtask

    initial begin
        int          k;
        int          gap;
        int          dn;
        logic [33:0] exp;
        clear_prev();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sum", sum_o, 32'h0);
        chk("rst_cout", 32'(cout_o), 32'h0);
        chk("rst_ovf", 32'(ovf_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed WIDTH=8 vectors
        sel = 8;
        op(32'h3C, 32'h5A, 1'b0, 1'b0);
        chk("v1_sum", sum_o, 32'h96); chk("v1_cout", 32'(cout_o), 32'h0); chk("v1_ovf", 32'(ovf_o), 32'h1);
        op(32'hFF, 32'h01, 1'b1, 1'b0);
        chk("v2_sum", sum_o, 32'h01); chk("v2_cout", 32'(cout_o), 32'h1); chk("v2_ovf", 32'(ovf_o), 32'h0);
        op(32'h10, 32'h20, 1'b0, 1'b1);
        chk("v3_sum", sum_o, 32'hF0); chk("v3_cout", 32'(cout_o), 32'h0); chk("v3_ovf", 32'(ovf_o), 32'h0);
        op(32'h80, 32'h01, 1'b1, 1'b1);
        chk("v4_sum", sum_o, 32'h7F); chk("v4_cout", 32'(cout_o), 32'h1); chk("v4_ovf", 32'(ovf_o), 32'h1);

        // Result must stay put across idle cycles
        repeat (5) @(negedge clk);
        chk("idle_sum", sum_o, 32'h7F);

        // Random WIDTH=8 operations
        for (int i = 0; i < 20; i++) begin
            op($urandom, $urandom, 1'($urandom), 1'($urandom));
        end

        // start held high: back-to-back period is WIDTH+2
        @(negedge clk);
        a_drv = 32'h5D; b_drv = 32'hC3; cin_drv = 1'b1; sub_drv = 1'b0; start_drv = 1'b1;
        exp = model(8, 32'h5D, 32'hC3, 1'b1, 1'b0);
        k = 0;
        while (!done_o && k < 30) begin @(negedge clk); k++; end
        chk("held_first_done", 32'(done_o), 32'h1);
        gap = 0;
        do begin @(negedge clk); gap++; end while (!done_o && gap < 30);
        start_drv = 1'b0;
        chk("held_period", 32'(gap), 32'd10);
        chk("held_sum", sum_o, exp[31:0]);
        prev_sum[1] = exp[31:0]; prev_cout[1] = exp[32]; prev_ovf[1] = exp[33];
        dn = 0;
        repeat (15) begin @(negedge clk); if (done_o || busy_o) dn++; end
        chk("held_no_third", 32'(dn), 32'd0);

        // Reset in the middle of AA+55
        @(negedge clk);
        a_drv = 32'hAA; b_drv = 32'h55; cin_drv = 1'b0; sub_drv = 1'b0; start_drv = 1'b1;
        @(posedge clk);
        #1 start_drv = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", 32'(busy_o), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_sum", sum_o, 32'h0);
        chk("mid_rst_cout", 32'(cout_o), 32'h0);
        chk("mid_rst_ovf", 32'(ovf_o), 32'h0);
        chk("mid_rst_busy", 32'(busy_o), 32'h0);
        chk("mid_rst_done", 32'(done_o), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        clear_prev();
        dn = 0;
        repeat (12) begin @(negedge clk); if (done_o) dn++; end
        chk("mid_rst_no_done", 32'(dn), 32'd0);
        op(32'h01, 32'h01, 1'b0, 1'b0);
        chk("post_rst_sum", sum_o, 32'h02);

        // WIDTH=16 instance
        sel = 16;
        op(32'hFFFF, 32'h0001, 1'b0, 1'b0);
        chk("w16_sum", sum_o, 32'h0000); chk("w16_cout", 32'(cout_o), 32'h1); chk("w16_ovf", 32'(ovf_o), 32'h0);
        for (int i = 0; i < 6; i++) begin
            op($urandom, $urandom, 1'($urandom), 1'($urandom));
        end

        // Exhaustive WIDTH=4
        sel = 4;
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int m = 0; m < 4; m++) begin
                    op(32'(av), 32'(bv), m[0], m[1]);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop, processing one operand bit per clock, LSB first.
- Successor to the combinational full-adder lab block. Adds a WIDTH parameter, a subtract mode and a start/busy/done handshake.
- Sits behind a controller that launches an operation and waits for done before reading the result.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a new operation; sampled only in IDLE.
- sub, input, 1, 0 = a+b+cin, 1 = a-b (cin ignored); captured at start.
- a, input, WIDTH, operand A; captured at start.
- b, input, WIDTH, operand B; captured at start.
- cin, input, 1, carry-in for add mode; captured at start.
- sum, output, WIDTH, result; valid from done until the next accepted start.
- cout, output, 1, carry out of the MSB; in subtract mode 1 = no borrow.
- overflow, output, 1, signed two's-complement overflow.
- busy, output, 1, high while in RUN.
- done, output, 1, one-cycle pulse when the result is valid.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - reset_n=0 immediately forces state to IDLE.
  - sum, cout, overflow, busy and done all go to 0; internal shift registers, carry FF and bit counter also clear.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1 at a rising edge, capture operands.
    - Capture A into shift register sa.
    - Capture B into shift register sb; B is inverted first when sub=1.
    - Load carry FF with cin (sub=0) or with 1 (sub=1).
    - Clear the bit counter, go to RUN.
    - sum/cout/overflow keep their previous values until the first RUN edge.
  - RUN: busy=1. On each edge:
    - s_bit = sa[0]^sb[0]^c; c_next = majority(sa[0], sb[0], c).
    - s_bit shifts into the MSB of the sum register (right shift); sa and sb shift right.
    - The counter increments.
    - On the edge that processes bit WIDTH-1: record c (carry into the MSB) for overflow, set cout=c_next and overflow=c^c_next, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE unconditionally.
- Latency: start accepted at edge 0; done is high in the cycle after edge WIDTH. WIDTH+1 cycles from the start edge to the done-low edge.
- start asserted in RUN or DONE is ignored; it is not queued.
- a, b, cin and sub may change freely after capture with no effect on the result.
- start held high continuously: a new operation begins on the first IDLE edge after DONE, so the back-to-back period is WIDTH+2 cycles.
- Width rules:
  - The bit counter is $clog2(WIDTH) bits wide.
  - Results are modulo 2^WIDTH; no saturation.
  - sum, cout and overflow are registered outputs, stable between operations.

Test Plan:
- WIDTH=8, add: a=8'h3C, b=8'h5A, cin=0 -> sum=8'h96, cout=0, overflow=1; done high exactly in the cycle after the 8th edge following the start edge; busy high for 8 cycles.
- WIDTH=8, add with carry-in: a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1, overflow=0.
- WIDTH=8, subtract:
  - a=8'h10, b=8'h20, sub=1 -> sum=8'hF0, cout=0, overflow=0.
  - Then a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, overflow=1.
- Handshake robustness:
  - Pulse start and change a/b at bit 3 of RUN -> result still from the captured operands.
  - Exactly one done pulse.
  - Previous sum held stable until the next start.
- Reset mid-run: drop reset_n at RUN bit 4 of an 8'hAA+8'h55 operation -> all outputs 0 immediately, no done. After release, start 8'h01+8'h01 -> sum=8'h02.
- WIDTH=16 instance: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, overflow=0, done 16 edges after start. Exhaustive loop over all WIDTH=4 a, b, cin and sub combinations matches a behavioural model.
